ramfifo_ctx_drain: RTL and testbench

- Downstream consumer of the multi-context RAMFIFO.
- Watches the per-context empty vector and picks a non-empty context with a round-robin arbiter.
- Drives the FIFO's read-context id and read strobe, then captures the returned word together with its context id.
- Presents the word on a valid/ready stream through a 2-entry output buffer, sustaining one word per cycle.

---
 rtl/ramfifo_ctx_drain.sv | 79 +++++++
 tb/tb_ramfifo_ctx_drain.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ramfifo_ctx_drain.sv
// ramfifo_ctx_drain: round-robin drain of a multi-context RAMFIFO (fifo_empty/fifo_data/ctx_enable in, fifo_read/fifo_rctx_id out) into a 2-entry valid/ready output buffer (out_data/out_ctx/out_valid, out_ready in)
module ramfifo_ctx_drain #(
  parameter int WIDTH = 36,
  parameter int LOG_CTX = 3,
  localparam int NUM_CTX = 1 << LOG_CTX
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CTX-1:0]       ctx_enable,
  input  logic [NUM_CTX-1:0]       fifo_empty,
  input  logic [NUM_CTX*WIDTH-1:0] fifo_data,
  output logic [LOG_CTX-1:0]       fifo_rctx_id,
  output logic                     fifo_read,
  output logic [WIDTH-1:0]         out_data,
  output logic [LOG_CTX-1:0]       out_ctx,
  output logic                     out_valid,
  input  logic                     out_ready
);
  logic [1:0] occ;
  logic pend;
  logic [LOG_CTX-1:0] pend_ctx, rr_ptr, rctx_q, grant, idx;
  logic [WIDTH-1:0] buf_data [2];
  logic [LOG_CTX-1:0] buf_ctx [2];
  logic [NUM_CTX-1:0] eligible;
  logic pop, allowed, issue, wr_idx;
  logic [WIDTH-1:0] push_data;
  assign eligible = ~fifo_empty & ctx_enable;
  assign pop = (occ != 2'd0) && out_ready;
  assign allowed = ({1'b0, occ} + {2'b0, pend} - {2'b0, pop}) < 3'd2;
  assign issue = !reset && allowed && (|eligible);
  assign wr_idx = occ[1] || (occ[0] && !pop);
  assign push_data = fifo_data[pend_ctx*WIDTH +: WIDTH];
  assign fifo_read = issue;
  assign fifo_rctx_id = issue ? grant : rctx_q;
  assign out_data = buf_data[0];
  assign out_ctx = buf_ctx[0];
  assign out_valid = occ != 2'd0;
  always_comb begin
    grant = rr_ptr;
    idx = '0;
    for (int k = NUM_CTX - 1; k >= 0; k--) begin
      idx = rr_ptr + k[LOG_CTX-1:0];
      grant = eligible[idx] ? idx : grant;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      occ <= '0;
      pend <= 1'b0;
      pend_ctx <= '0;
      rr_ptr <= '0;
      rctx_q <= '0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_ctx[0] <= '0;
      buf_ctx[1] <= '0;
    end else begin
      pend <= issue;
      if (issue) begin
        pend_ctx <= grant;
        rr_ptr <= grant + 1'b1;
        rctx_q <= grant;
      end
      occ <= occ + {1'b0, pend} - {1'b0, pop};
      if (pop) begin
        buf_data[0] <= buf_data[1];
        buf_ctx[0] <= buf_ctx[1];
      end
      if (pend && wr_idx) begin
        buf_data[1] <= push_data;
        buf_ctx[1] <= pend_ctx;
      end
      if (pend && !wr_idx) begin
        buf_data[0] <= push_data;
        buf_ctx[0] <= pend_ctx;
      end
    end
  end
endmodule

// File: tb/tb_ramfifo_ctx_drain.sv
// tb_ramfifo_ctx_drain: randomized and directed check of ramfifo_ctx_drain against a queue-based reference model
module tb_ramfifo_ctx_drain;
  localparam int WIDTH = 36;
  localparam int LOG_CTX = 3;
  localparam int NUM_CTX = 8;
  typedef struct packed {
    logic [LOG_CTX-1:0] c;
    logic [WIDTH-1:0] d;
  } ent_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NUM_CTX-1:0] ctx_enable = '1;
  logic [NUM_CTX-1:0] fifo_empty = '1;
  logic [NUM_CTX*WIDTH-1:0] fifo_data = '0;
  logic [LOG_CTX-1:0] fifo_rctx_id;
  logic fifo_read;
  logic [WIDTH-1:0] out_data;
  logic [LOG_CTX-1:0] out_ctx;
  logic out_valid;
  logic out_ready = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] q [NUM_CTX][$];
  logic [WIDTH-1:0] dreg [NUM_CTX];
  ent_t m_buf [$];
  int m_rr = 0, m_rctx = 0, m_pend = 0, m_pend_ctx = 0;
  logic [NUM_CTX-1:0] en_v = '1;
  logic rdy_v = 1'b1;
  logic rst_v = 1'b1;
  int n_reads = 0;
  int seq = 0;
  int base;
  always #5 clock = ~clock;
  ramfifo_ctx_drain #(.WIDTH(WIDTH), .LOG_CTX(LOG_CTX)) dut (
    .clock(clock), .reset(reset), .ctx_enable(ctx_enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rctx_id(fifo_rctx_id), .fifo_read(fifo_read),
    .out_data(out_data), .out_ctx(out_ctx), .out_valid(out_valid), .out_ready(out_ready)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive_env();
    for (int i = 0; i < NUM_CTX; i++) begin
      fifo_empty[i] = q[i].size() == 0;
      fifo_data[i*WIDTH +: WIDTH] = dreg[i];
    end
  endtask
  task automatic load(input int c, input int n);
    for (int j = 0; j < n; j++) begin
      q[c].push_back({4'(c), 32'(seq)});
      seq++;
    end
    drive_env();
  endtask
  task automatic cycle();
    int bsz, g, rd_ctx;
    logic any, exp_read, pop, allowed;
    logic [WIDTH-1:0] rd_word;
    ent_t e;
    reset = rst_v;
    ctx_enable = en_v;
    out_ready = rdy_v;
    #1;
    bsz = m_buf.size();
    pop = (bsz != 0) && rdy_v;
    allowed = (bsz + m_pend - int'(pop)) < 2;
    any = 1'b0;
    g = 0;
    for (int k = 0; k < NUM_CTX; k++) begin
      int i;
      i = (m_rr + k) % NUM_CTX;
      if (!any && q[i].size() != 0 && en_v[i]) begin
        any = 1'b1;
        g = i;
      end
    end
    exp_read = !rst_v && allowed && any;
    check("fifo_read", fifo_read, exp_read);
    check("fifo_rctx_id", fifo_rctx_id, exp_read ? g : m_rctx);
    check("out_valid", out_valid, bsz != 0);
    if (bsz != 0) begin
      check("out_data", out_data, m_buf[0].d);
      check("out_ctx", out_ctx, m_buf[0].c);
    end
    check("overflow", (dut.occ == 2'd2) && dut.pend && !pop, 0);
    if (pop) void'(m_buf.pop_front());
    if (m_pend != 0) begin
      e.c = 3'(m_pend_ctx);
      e.d = dreg[m_pend_ctx];
      m_buf.push_back(e);
    end
    if (rst_v) begin
      m_buf.delete();
      m_pend = 0;
      m_pend_ctx = 0;
      m_rr = 0;
      m_rctx = 0;
    end else begin
      m_pend = int'(exp_read);
      if (exp_read) begin
        m_pend_ctx = g;
        m_rr = (g + 1) % NUM_CTX;
        m_rctx = g;
      end
    end
    rd_ctx = -1;
    rd_word = '0;
    if (fifo_read === 1'b1) begin
      n_reads++;
      rd_ctx = int'(fifo_rctx_id);
      if (q[rd_ctx].size() != 0) rd_word = q[rd_ctx].pop_front();
    end
    @(posedge clock);
    #1;
    if (rd_ctx >= 0) dreg[rd_ctx] = rd_word;
    drive_env();
  endtask
  function automatic logic busy();
    busy = (m_buf.size() != 0) || (m_pend != 0);
    for (int i = 0; i < NUM_CTX; i++) if (q[i].size() != 0) busy = 1'b1;
  endfunction
  task automatic drain();
    int n;
    en_v = '1;
    rdy_v = 1'b1;
    rst_v = 1'b0;
    n = 0;
    while (busy() && n < 300) begin
      cycle();
      n++;
    end
    check("drain_done", busy(), 0);
  endtask
  initial begin
    for (int i = 0; i < NUM_CTX; i++) dreg[i] = '0;
    for (int i = 0; i < NUM_CTX; i++) load(i, 2);
    @(posedge clock);
    #1;
    rst_v = 1'b1;
    repeat (3) cycle();
    check("rst_out_data", out_data, 0);
    check("rst_out_ctx", out_ctx, 0);
    check("rst_rctx", fifo_rctx_id, 0);
    rst_v = 1'b0;
    drain();
    base = n_reads;
    load(1, 2);
    load(3, 2);
    load(6, 2);
    drain();
    check("rr_reads", n_reads - base, 6);
    base = n_reads;
    rdy_v = 1'b0;
    load(2, 5);
    repeat (8) cycle();
    check("bp_reads", n_reads - base, 2);
    drain();
    check("bp_total", n_reads - base, 5);
    for (int i = 0; i < NUM_CTX; i++) load(i, 3);
    en_v = 8'b0000_0101;
    repeat (10) cycle();
    drain();
    base = n_reads;
    load(4, 1);
    repeat (6) cycle();
    check("empty_reads", n_reads - base, 1);
    load(2, 3);
    load(5, 4);
    rdy_v = 1'b0;
    repeat (4) cycle();
    rdy_v = 1'b1;
    cycle();
    rdy_v = 1'b0;
    rst_v = 1'b1;
    repeat (2) cycle();
    rst_v = 1'b0;
    drain();
    for (int t = 0; t < 600; t++) begin
      en_v = ($urandom_range(0, 3) == 0) ? 8'($urandom) : '1;
      rdy_v = $urandom_range(0, 2) != 0;
      rst_v = $urandom_range(0, 99) == 0;
      cycle();
      if ($urandom_range(0, 2) == 0) load($urandom_range(0, NUM_CTX - 1), $urandom_range(1, 3));
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
